// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm scheduler slice.
// Holds the FSM state encoding, the time field width and the wrap limits
// for hours, minutes and seconds.
package alarm_pkg;

   localparam int unsigned TIME_W = 11;

   typedef logic [TIME_W-1:0] time_t;

   localparam time_t HOURS = time_t'(24);
   localparam time_t MINS  = time_t'(60);
   localparam time_t SECS  = time_t'(60);

   // The encoding is visible on the state output, so the values are fixed.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2
   } state_t;

   // A time that is out of range must never produce a hit.
   function automatic logic time_valid(input time_t h, input time_t m, input time_t s);
      return (h < HOURS) && (m < MINS) && (s < SECS);
   endfunction

endpackage

// File: rtl/hms_add_min.sv
// Combinational hour:minute + ADD_MIN minutes.
// The minute wraps at 60 and carries into the hour, and the hour wraps at 24.
// ADD_MIN must be below 60, so at most one carry can occur.
// Ports:
//   hour, minute          in   current hour and minute
//   sum_hour, sum_minute  out  hour and minute ADD_MIN minutes later
module hms_add_min
   import alarm_pkg::*;
#(
   parameter int ADD_MIN = 5
) (
   input  logic [TIME_W-1:0] hour,
   input  logic [TIME_W-1:0] minute,
   output logic [TIME_W-1:0] sum_hour,
   output logic [TIME_W-1:0] sum_minute
);

   time_t min_sum;
   time_t hour_inc;

   // Add the minutes. A carry moves the result one hour forward, and 23
   // rolls over to hour 0. Out-of-range inputs pass through uncorrected.
   always_comb begin
      min_sum    = minute + time_t'(ADD_MIN);
      hour_inc   = hour + time_t'(1);
      sum_minute = min_sum;
      sum_hour   = hour;
      if (min_sum >= MINS) begin
         sum_minute = min_sum - MINS;
         sum_hour   = (hour_inc >= HOURS) ? '0 : hour_inc;
      end
   end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller. Every alarm slot shares one buzzer output.
// Ports:
//   newclk, rst               clock, and synchronous active-high reset
//   sec_tick, hour/minute/second
//                             running clock. A new time is valid on sec_tick.
//   cfg_we, cfg_slot, cfg_*   slot register write port
//   snooze, dismiss           one-cycle button pulses
//   ring                      buzzer enable
//   ring_slot                 slot that is ringing or snoozed
//   state                     0=IDLE 1=RING 2=SNOOZE
//   pending                   slots that hit and have not been served yet
//   snooze_cnt                snoozes used in the current event
module alarm_scheduler
   import alarm_pkg::*;
#(
   parameter int NUM_SLOTS      = 4,
   parameter int RING_TIMEOUT_S = 60,
   parameter int SNOOZE_MIN     = 5,
   parameter int MAX_SNOOZE     = 3,
   localparam int SW            = $clog2(NUM_SLOTS)
) (
   input  logic                 newclk,
   input  logic                 rst,
   input  logic                 sec_tick,
   input  logic [TIME_W-1:0]    hour,
   input  logic [TIME_W-1:0]    minute,
   input  logic [TIME_W-1:0]    second,
   input  logic                 cfg_we,
   input  logic [SW-1:0]        cfg_slot,
   input  logic [TIME_W-1:0]    cfg_hour,
   input  logic [TIME_W-1:0]    cfg_minute,
   input  logic [TIME_W-1:0]    cfg_second,
   input  logic                 cfg_arm,
   input  logic                 snooze,
   input  logic                 dismiss,
   output logic                 ring,
   output logic [SW-1:0]        ring_slot,
   output logic [1:0]           state,
   output logic [NUM_SLOTS-1:0] pending,
   output logic [1:0]           snooze_cnt
);

   localparam int TW = $clog2(RING_TIMEOUT_S + 1);

   time_t                slot_hour   [NUM_SLOTS];
   time_t                slot_minute [NUM_SLOTS];
   time_t                slot_second [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] armed;

   logic [NUM_SLOTS-1:0] pending_q;
   logic [NUM_SLOTS-1:0] match;
   logic [NUM_SLOTS-1:0] ring_mask;
   logic [NUM_SLOTS-1:0] hit_mask;
   logic [NUM_SLOTS-1:0] clear_mask;
   logic [SW-1:0]        first_idx;

   state_t               state_q, state_d;
   logic [SW-1:0]        ring_slot_q, ring_slot_d;
   logic [1:0]           snooze_cnt_q, snooze_cnt_d;
   logic [TW-1:0]        timer_q, timer_d;
   time_t                tgt_hour_q, tgt_hour_d;
   time_t                tgt_minute_q, tgt_minute_d;
   time_t                tgt_second_q, tgt_second_d;

   time_t                snz_hour, snz_minute;
   logic                 now_valid;
   logic                 abort;
   logic                 end_event;
   logic                 timeout;
   logic                 snz_hit;

   hms_add_min #(
      .ADD_MIN (SNOOZE_MIN)
   ) u_snooze_add (
      .hour       (hour),
      .minute     (minute),
      .sum_hour   (snz_hour),
      .sum_minute (snz_minute)
   );

   // Slot register file. A write to an index outside NUM_SLOTS is dropped.
   always_ff @(posedge newclk) begin
      if (rst) begin
         armed <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_hour[i]   <= '0;
            slot_minute[i] <= '0;
            slot_second[i] <= '0;
         end
      end else if (cfg_we) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (cfg_slot == SW'(i)) begin
               slot_hour[i]   <= cfg_hour;
               slot_minute[i] <= cfg_minute;
               slot_second[i] <= cfg_second;
               armed[i]       <= cfg_arm;
            end
         end
      end
   end

   // Compare only on sec_tick. Each armed slot therefore hits at most once
   // per second of wall time, which is once per day.
   always_comb begin
      now_valid = time_valid(hour, minute, second);
      match     = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         match[i] = sec_tick && now_valid && armed[i] &&
                    (slot_hour[i] == hour) && (slot_minute[i] == minute) &&
                    (slot_second[i] == second);
      end
   end

   // The lowest-index pending slot is served first.
   always_comb begin
      first_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (pending_q[i]) first_idx = SW'(i);
      end
   end

   // Next-state logic. The checks run in priority order:
   //   1. a cfg write to the active slot aborts the event
   //   2. dismiss
   //   3. snooze
   //   4. ring timeout
   // A snooze or timeout after the last allowed snooze ends the event the
   // same way a dismiss does.
   always_comb begin
      state_d      = state_q;
      ring_slot_d  = ring_slot_q;
      snooze_cnt_d = snooze_cnt_q;
      timer_d      = timer_q;
      tgt_hour_d   = tgt_hour_q;
      tgt_minute_d = tgt_minute_q;
      tgt_second_d = tgt_second_q;
      end_event    = 1'b0;

      abort   = cfg_we && (cfg_slot == ring_slot_q) && (state_q != ST_IDLE);
      timeout = (timer_q == TW'(RING_TIMEOUT_S));
      snz_hit = sec_tick && now_valid && (hour == tgt_hour_q) &&
                (minute == tgt_minute_q) && (second == tgt_second_q);

      case (state_q)
         ST_IDLE: begin
            if (|pending_q) begin
               state_d      = ST_RING;
               ring_slot_d  = first_idx;
               snooze_cnt_d = '0;
               timer_d      = '0;
            end
         end
         ST_RING: begin
            if (sec_tick && !timeout) timer_d = timer_q + TW'(1);
            if (dismiss) begin
               end_event = 1'b1;
            end else if (snooze || timeout) begin
               if (snooze_cnt_q < 2'(MAX_SNOOZE)) begin
                  state_d      = ST_SNOOZE;
                  snooze_cnt_d = snooze_cnt_q + 2'd1;
                  tgt_hour_d   = snz_hour;
                  tgt_minute_d = snz_minute;
                  tgt_second_d = second;
               end else begin
                  end_event = 1'b1;
               end
            end
         end
         ST_SNOOZE: begin
            if (dismiss) begin
               end_event = 1'b1;
            end else if (snz_hit) begin
               state_d = ST_RING;
               timer_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (end_event || abort) state_d = ST_IDLE;
   end

   // Pending update. A new hit sets its bit. The exception is a re-hit of the
   // slot that is already active, which is ignored. The active slot's bit is
   // cleared when its event ends.
   always_comb begin
      ring_mask  = NUM_SLOTS'(1) << ring_slot_q;
      hit_mask   = (state_q != ST_IDLE) ? ring_mask : '0;
      clear_mask = (end_event || abort) ? ring_mask : '0;
   end

   // State register.
   always_ff @(posedge newclk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ring_slot_q  <= '0;
         snooze_cnt_q <= '0;
         timer_q      <= '0;
         tgt_hour_q   <= '0;
         tgt_minute_q <= '0;
         tgt_second_q <= '0;
         pending_q    <= '0;
      end else begin
         state_q      <= state_d;
         ring_slot_q  <= ring_slot_d;
         snooze_cnt_q <= snooze_cnt_d;
         timer_q      <= timer_d;
         tgt_hour_q   <= tgt_hour_d;
         tgt_minute_q <= tgt_minute_d;
         tgt_second_q <= tgt_second_d;
         pending_q    <= (pending_q | (match & ~hit_mask)) & ~clear_mask;
      end
   end

   assign ring       = (state_q == ST_RING);
   assign ring_slot  = ring_slot_q;
   assign state      = state_q;
   assign pending    = pending_q;
   assign snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed testbench for alarm_scheduler. Every expected value is worked out
// by hand from the intended alarm behaviour.
module tb_alarm_scheduler;

   logic        newclk;
   logic        rst;
   logic        sec_tick;
   logic [10:0] hour, minute, second;
   logic        cfg_we;
   logic [1:0]  cfg_slot;
   logic [10:0] cfg_hour, cfg_minute, cfg_second;
   logic        cfg_arm;
   logic        snooze, dismiss;
   logic        ring;
   logic [1:0]  ring_slot;
   logic [1:0]  state;
   logic [3:0]  pending;
   logic [1:0]  snooze_cnt;

   int checks = 0;
   int errors = 0;
   int cur_h, cur_m, cur_s;

   alarm_scheduler #(
      .NUM_SLOTS      (4),
      .RING_TIMEOUT_S (60),
      .SNOOZE_MIN     (5),
      .MAX_SNOOZE     (3)
   ) dut (
      .newclk     (newclk),
      .rst        (rst),
      .sec_tick   (sec_tick),
      .hour       (hour),
      .minute     (minute),
      .second     (second),
      .cfg_we     (cfg_we),
      .cfg_slot   (cfg_slot),
      .cfg_hour   (cfg_hour),
      .cfg_minute (cfg_minute),
      .cfg_second (cfg_second),
      .cfg_arm    (cfg_arm),
      .snooze     (snooze),
      .dismiss    (dismiss),
      .ring       (ring),
      .ring_slot  (ring_slot),
      .state      (state),
      .pending    (pending),
      .snooze_cnt (snooze_cnt)
   );

   initial begin
      newclk = 1'b0;
      forever #5 newclk = ~newclk;
   end

   // Compares one observed value against its expected value and counts the result.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Checks the main observable state in one call.
   task automatic checkState(input string tag, input int exp_state, input int exp_ring,
                             input int exp_pending);
      checkOutput({tag, ".state"}, 32'(state), 32'(exp_state));
      checkOutput({tag, ".ring"}, 32'(ring), 32'(exp_ring));
      checkOutput({tag, ".pending"}, 32'(pending), 32'(exp_pending));
   endtask

   // Runs one clock edge and returns 1 time unit after it, so that outputs
   // are sampled away from the edge and pulses last exactly one cycle.
   task automatic applyStimulus;
      @(posedge newclk);
      #1;
      sec_tick = 1'b0;
      cfg_we   = 1'b0;
      snooze   = 1'b0;
      dismiss  = 1'b0;
   endtask

   task automatic tickAt(input int h, input int m, input int s);
      cur_h    = h;
      cur_m    = m;
      cur_s    = s;
      hour     = 11'(h);
      minute   = 11'(m);
      second   = 11'(s);
      sec_tick = 1'b1;
      applyStimulus();
   endtask

   // Advances the bench's own wall clock n seconds, one tick per cycle.
   task automatic advanceSeconds(input int n);
      for (int k = 0; k < n; k++) begin
         int s, m, h;
         s = cur_s + 1;
         m = cur_m;
         h = cur_h;
         if (s == 60) begin s = 0; m = m + 1; end
         if (m == 60) begin m = 0; h = h + 1; end
         if (h == 24) h = 0;
         tickAt(h, m, s);
      end
   endtask

   task automatic cfgWrite(input int slot, input int h, input int m, input int s, input logic arm);
      cfg_slot   = 2'(slot);
      cfg_hour   = 11'(h);
      cfg_minute = 11'(m);
      cfg_second = 11'(s);
      cfg_arm    = arm;
      cfg_we     = 1'b1;
      applyStimulus();
   endtask

   task automatic pulse(input logic sn, input logic dis);
      snooze  = sn;
      dismiss = dis;
      applyStimulus();
   endtask

   initial begin
      rst = 1'b1;
      sec_tick = 1'b0;
      hour = '0; minute = '0; second = '0;
      cfg_we = 1'b0; cfg_slot = '0; cfg_hour = '0; cfg_minute = '0; cfg_second = '0; cfg_arm = 1'b0;
      snooze = 1'b0; dismiss = 1'b0;
      cur_h = 0; cur_m = 0; cur_s = 0;
      applyStimulus();
      applyStimulus();
      checkState("reset", 0, 0, 0);
      checkOutput("reset.ring_slot", 32'(ring_slot), 0);
      checkOutput("reset.snooze_cnt", 32'(snooze_cnt), 0);
      rst = 1'b0;
      applyStimulus();

      $display("[TB] slot0 07:00:00 with snooze and repeated timeouts");
      cfgWrite(0, 7, 0, 0, 1'b1);
      tickAt(6, 59, 59);
      checkState("pre_hit", 0, 0, 0);
      tickAt(7, 0, 0);
      checkState("hit", 0, 0, 1);
      applyStimulus();
      checkState("ring1", 1, 1, 1);
      checkOutput("ring1.slot", 32'(ring_slot), 0);
      checkOutput("ring1.cnt", 32'(snooze_cnt), 0);
      advanceSeconds(10);
      pulse(1'b1, 1'b0);
      checkState("snz1", 2, 0, 1);
      checkOutput("snz1.cnt", 32'(snooze_cnt), 1);
      tickAt(7, 5, 9);
      checkState("snz1_wait", 2, 0, 1);
      tickAt(7, 5, 10);
      checkState("resume1", 1, 1, 1);
      advanceSeconds(59);
      checkState("t59", 1, 1, 1);
      advanceSeconds(1);
      checkState("t60", 1, 1, 1);
      applyStimulus();
      checkState("timeout1", 2, 0, 1);
      checkOutput("timeout1.cnt", 32'(snooze_cnt), 2);
      tickAt(7, 11, 10);
      checkState("resume2", 1, 1, 1);
      advanceSeconds(60);
      applyStimulus();
      checkOutput("timeout2.cnt", 32'(snooze_cnt), 3);
      tickAt(7, 17, 10);
      checkState("resume3", 1, 1, 1);
      advanceSeconds(60);
      applyStimulus();
      checkState("final_timeout", 0, 0, 0);

      $display("[TB] simultaneous hits on slots 1 and 2");
      cfgWrite(2, 12, 0, 0, 1'b1);
      cfgWrite(1, 12, 0, 0, 1'b1);
      tickAt(11, 59, 59);
      tickAt(12, 0, 0);
      checkState("dual_hit", 0, 0, 6);
      applyStimulus();
      checkState("dual_ring1", 1, 1, 6);
      checkOutput("dual_ring1.slot", 32'(ring_slot), 1);
      pulse(1'b0, 1'b1);
      checkState("dual_dis1", 0, 0, 4);
      applyStimulus();
      checkState("dual_ring2", 1, 1, 4);
      checkOutput("dual_ring2.slot", 32'(ring_slot), 2);
      pulse(1'b0, 1'b1);
      checkState("dual_dis2", 0, 0, 0);

      $display("[TB] snooze across midnight");
      cfgWrite(3, 23, 58, 0, 1'b1);
      tickAt(23, 58, 0);
      applyStimulus();
      checkOutput("mid_ring.slot", 32'(ring_slot), 3);
      tickAt(23, 58, 30);
      pulse(1'b1, 1'b0);
      checkState("mid_snz", 2, 0, 8);
      tickAt(0, 3, 29);
      checkState("mid_wait", 2, 0, 8);
      tickAt(0, 3, 30);
      checkState("mid_resume", 1, 1, 8);
      pulse(1'b1, 1'b1);
      checkState("snz_and_dis", 0, 0, 0);

      $display("[TB] automatic snooze after the ring timeout");
      cfgWrite(0, 8, 0, 0, 1'b1);
      tickAt(8, 0, 0);
      applyStimulus();
      checkState("auto_ring", 1, 1, 1);
      advanceSeconds(60);
      applyStimulus();
      checkState("auto_snz", 2, 0, 1);
      checkOutput("auto_snz.cnt", 32'(snooze_cnt), 1);
      pulse(1'b0, 1'b1);
      checkState("auto_dis", 0, 0, 0);

      $display("[TB] out-of-range time never matches");
      cfgWrite(0, 25, 0, 0, 1'b1);
      tickAt(25, 0, 0);
      checkState("bad_time", 0, 0, 0);

      $display("[TB] cfg write aborts the ringing slot");
      cfgWrite(1, 9, 0, 0, 1'b1);
      tickAt(9, 0, 0);
      applyStimulus();
      checkState("abort_ring", 1, 1, 2);
      cfgWrite(1, 9, 30, 0, 1'b1);
      checkState("abort", 0, 0, 0);

      $display("[TB] reset while ringing");
      cfgWrite(2, 10, 0, 0, 1'b1);
      tickAt(10, 0, 0);
      applyStimulus();
      checkOutput("rst_ring.slot", 32'(ring_slot), 2);
      rst = 1'b1;
      applyStimulus();
      checkState("rst_mid", 0, 0, 0);
      checkOutput("rst_mid.slot", 32'(ring_slot), 0);
      checkOutput("rst_mid.cnt", 32'(snooze_cnt), 0);
      rst = 1'b0;
      tickAt(10, 0, 0);
      checkState("rst_disarmed", 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
